// File: rtl/moment_ram_arbiter.sv
// Two-port arbiter in front of the single-port moment_ram.
// Grants one requester per cycle and routes read data back to its issuer.
module moment_ram_arbiter #(
    parameter int DEPTH          = 256,
    parameter int ADDRESS_WIDTH  = $clog2(DEPTH),
    parameter int DATA_WIDTH     = 32,
    parameter int READ_LATENCY   = 1,
    parameter bit FIXED_PRIORITY = 1'b0
) (
    input  logic                         Clk,
    input  logic                         Reset,
    input  logic                         p0_req,
    input  logic                         p0_we,
    input  logic [ADDRESS_WIDTH-1:0]     p0_addr,
    input  logic signed [DATA_WIDTH-1:0] p0_wdata,
    output logic                         p0_gnt,
    output logic                         p0_rvalid,
    output logic signed [DATA_WIDTH-1:0] p0_rdata,
    input  logic                         p1_req,
    input  logic                         p1_we,
    input  logic [ADDRESS_WIDTH-1:0]     p1_addr,
    input  logic signed [DATA_WIDTH-1:0] p1_wdata,
    output logic                         p1_gnt,
    output logic                         p1_rvalid,
    output logic signed [DATA_WIDTH-1:0] p1_rdata,
    output logic [ADDRESS_WIDTH-1:0]     address,
    output logic                         WE,
    output logic signed [DATA_WIDTH-1:0] data_in,
    input  logic signed [DATA_WIDTH-1:0] data_out
);

    typedef struct packed {
        logic valid;
        logic port;
        logic oor;
    } rd_entry_t;

    rd_entry_t pipe [READ_LATENCY];
    rd_entry_t rd_push;
    rd_entry_t rd_exit;
    logic      last_winner;
    logic      g0;
    logic      g1;
    logic      in0;
    logic      in1;

    generate
        if (DEPTH == (1 << ADDRESS_WIDTH)) begin : g_full
            assign in0 = 1'b1;
            assign in1 = 1'b1;
        end else begin : g_partial
            localparam logic [ADDRESS_WIDTH:0] DEPTH_W = (ADDRESS_WIDTH+1)'(DEPTH);
            assign in0 = {1'b0, p0_addr} < DEPTH_W;
            assign in1 = {1'b0, p1_addr} < DEPTH_W;
        end
    endgenerate

    // Tie goes to the port that did not win last; reset blocks all grants.
    always_comb begin
        g0 = 1'b0;
        g1 = 1'b0;
        if (!Reset) begin
            if (p0_req && (!p1_req || FIXED_PRIORITY || last_winner))
                g0 = 1'b1;
            else if (p1_req)
                g1 = 1'b1;
        end
    end

    assign p0_gnt = g0;
    assign p1_gnt = g1;

    always_comb begin
        address = '0;
        WE      = 1'b0;
        data_in = '0;
        rd_push = '0;
        if (g0) begin
            address = p0_addr;
            WE      = p0_we & in0;
            data_in = p0_wdata;
            rd_push = '{valid: ~p0_we, port: 1'b0, oor: ~in0};
        end else if (g1) begin
            address = p1_addr;
            WE      = p1_we & in1;
            data_in = p1_wdata;
            rd_push = '{valid: ~p1_we, port: 1'b1, oor: ~in1};
        end
    end

    assign rd_exit = pipe[READ_LATENCY-1];

    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int i = 0; i < READ_LATENCY; i++)
                pipe[i] <= '0;
            last_winner <= 1'b1;
            p0_rvalid   <= 1'b0;
            p1_rvalid   <= 1'b0;
            p0_rdata    <= '0;
            p1_rdata    <= '0;
        end else begin
            pipe[0] <= rd_push;
            for (int i = 1; i < READ_LATENCY; i++)
                pipe[i] <= pipe[i-1];
            if (g0 || g1)
                last_winner <= g1;
            p0_rvalid <= rd_exit.valid & ~rd_exit.port;
            p1_rvalid <= rd_exit.valid & rd_exit.port;
            // Out-of-range reads return zero instead of whatever the RAM drives.
            if (rd_exit.valid && !rd_exit.port)
                p0_rdata <= rd_exit.oor ? '0 : data_out;
            if (rd_exit.valid && rd_exit.port)
                p1_rdata <= rd_exit.oor ? '0 : data_out;
        end
    end

endmodule

// File: tb/tb_moment_ram_arbiter.sv
// Directed bench for moment_ram_arbiter with a behavioural 1-cycle RAM.
// A second instance checks the fixed-priority variant.
module tb_moment_ram_arbiter;

    logic               Clk = 1'b0;
    logic               Reset;
    logic               p0_req, p0_we, p1_req, p1_we;
    logic [7:0]         p0_addr, p1_addr;
    logic signed [31:0] p0_wdata, p1_wdata;
    logic               p0_gnt, p0_rvalid, p1_gnt, p1_rvalid;
    logic signed [31:0] p0_rdata, p1_rdata;
    logic [7:0]         address;
    logic               WE;
    logic signed [31:0] data_in;
    logic signed [31:0] data_out;

    logic               f0_req, f1_req;
    logic               f0_gnt, f1_gnt, f0_rvalid, f1_rvalid;
    logic signed [31:0] f0_rdata, f1_rdata, f_data_in;
    logic [7:0]         f_address;
    logic               f_we;
    logic signed [31:0] f_data_out;

    logic signed [31:0] mem [256];

    int checks = 0;
    int errors = 0;

    always #5 Clk = ~Clk;

    moment_ram_arbiter #(.FIXED_PRIORITY(1'b0)) dut (
        .Clk(Clk), .Reset(Reset),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
        .address(address), .WE(WE), .data_in(data_in), .data_out(data_out)
    );

    moment_ram_arbiter #(.FIXED_PRIORITY(1'b1)) dut_fp (
        .Clk(Clk), .Reset(Reset),
        .p0_req(f0_req), .p0_we(1'b0), .p0_addr(8'h02), .p0_wdata(32'sd0),
        .p0_gnt(f0_gnt), .p0_rvalid(f0_rvalid), .p0_rdata(f0_rdata),
        .p1_req(f1_req), .p1_we(1'b0), .p1_addr(8'h03), .p1_wdata(32'sd0),
        .p1_gnt(f1_gnt), .p1_rvalid(f1_rvalid), .p1_rdata(f1_rdata),
        .address(f_address), .WE(f_we), .data_in(f_data_in), .data_out(f_data_out)
    );

    initial begin
        for (int i = 0; i < 256; i++)
            mem[i] = '0;
    end

    always @(posedge Clk) begin
        if (WE)
            mem[address] <= data_in;
        data_out <= mem[address];
    end

    task automatic tick;
        @(posedge Clk);
        #1;
    endtask

    task automatic test_reset;
        Reset = 1'b1;
        p0_req = 1'b1; p0_we = 1'b1; p0_addr = 8'h40; p0_wdata = 32'hDEADBEEF;
        p1_req = 1'b1; p1_we = 1'b0; p1_addr = 8'h41;
        #1;
        checks++;
        if ({p0_gnt, p1_gnt} !== 2'b00) begin
            errors++;
            $display("FAIL reset_gnt: got %b expected 00", {p0_gnt, p1_gnt});
        end
        checks++;
        if (WE !== 1'b0) begin
            errors++;
            $display("FAIL reset_we: got %b expected 0", WE);
        end
        tick;
        tick;
        checks++;
        if ({p0_rvalid, p1_rvalid} !== 2'b00) begin
            errors++;
            $display("FAIL reset_rvalid: got %b expected 00", {p0_rvalid, p1_rvalid});
        end
        checks++;
        if (p0_rdata !== 32'h0 || p1_rdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_rdata: got %h/%h expected 0/0", p0_rdata, p1_rdata);
        end
        checks++;
        if (address !== 8'h00) begin
            errors++;
            $display("FAIL reset_address: got %h expected 00", address);
        end
        Reset = 1'b0;
        p0_req = 1'b0;
        p1_req = 1'b0;
    endtask

    task automatic test_single_write;
        p0_req = 1'b1; p0_we = 1'b1; p0_addr = 8'h01; p0_wdata = 32'h12345678;
        #1;
        checks++;
        if ({p0_gnt, p1_gnt, WE} !== 3'b101) begin
            errors++;
            $display("FAIL write_gnt_we: got %b expected 101", {p0_gnt, p1_gnt, WE});
        end
        checks++;
        if (address !== 8'h01 || data_in !== 32'h12345678) begin
            errors++;
            $display("FAIL write_drive: got %h/%h expected 01/12345678", address, data_in);
        end
        tick;
        p0_we = 1'b0;
        #1;
        checks++;
        if ({p0_gnt, WE} !== 2'b10) begin
            errors++;
            $display("FAIL read_gnt: got %b expected 10", {p0_gnt, WE});
        end
        tick;
        p0_req = 1'b0;
        #1;
        checks++;
        if (p0_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL read_early: got %b expected 0", p0_rvalid);
        end
        tick;
        checks++;
        if (p0_rvalid !== 1'b1 || p0_rdata !== 32'h12345678) begin
            errors++;
            $display("FAIL read_back: got %b/%h expected 1/12345678", p0_rvalid, p0_rdata);
        end
        tick;
        checks++;
        if (p0_rvalid !== 1'b0 || p0_rdata !== 32'h12345678) begin
            errors++;
            $display("FAIL read_pulse: got %b/%h expected 0/12345678", p0_rvalid, p0_rdata);
        end
    endtask

    task automatic test_round_robin;
        p0_req = 1'b1; p0_we = 1'b1; p0_addr = 8'h02; p0_wdata = 32'h22222222;
        tick;
        p0_req = 1'b0;
        p1_req = 1'b1; p1_we = 1'b1; p1_addr = 8'h03; p1_wdata = 32'h33333333;
        #1;
        checks++;
        if (p1_gnt !== 1'b1) begin
            errors++;
            $display("FAIL rr_setup_gnt: got %b expected 1", p1_gnt);
        end
        tick;
        p1_req = 1'b0;
        p0_we = 1'b0;
        p1_we = 1'b0;
        for (int k = 0; k < 8; k++) begin
            p0_req = (k < 6);
            p1_req = (k < 6);
            #1;
            if (k < 6) begin
                checks++;
                if ({p0_gnt, p1_gnt} !== {k % 2 == 0, k % 2 == 1}) begin
                    errors++;
                    $display("FAIL rr_gnt[%0d]: got %b expected %b", k,
                             {p0_gnt, p1_gnt}, {k % 2 == 0, k % 2 == 1});
                end
            end
            if (k >= 2) begin
                checks++;
                if ({p0_rvalid, p1_rvalid} !== {k % 2 == 0, k % 2 == 1}) begin
                    errors++;
                    $display("FAIL rr_rvalid[%0d]: got %b expected %b", k,
                             {p0_rvalid, p1_rvalid}, {k % 2 == 0, k % 2 == 1});
                end
                checks++;
                if (k % 2 == 0 && p0_rdata !== 32'h22222222) begin
                    errors++;
                    $display("FAIL rr_p0_rdata[%0d]: got %h expected 22222222", k, p0_rdata);
                end else if (k % 2 == 1 && p1_rdata !== 32'h33333333) begin
                    errors++;
                    $display("FAIL rr_p1_rdata[%0d]: got %h expected 33333333", k, p1_rdata);
                end
            end
            tick;
        end
    endtask

    task automatic test_signed_raw;
        p1_req = 1'b1; p1_we = 1'b1; p1_addr = 8'h12; p1_wdata = 32'hABCCCDEF;
        #1;
        checks++;
        if ({p1_gnt, WE} !== 2'b11) begin
            errors++;
            $display("FAIL raw_write: got %b expected 11", {p1_gnt, WE});
        end
        tick;
        p1_req = 1'b0;
        p0_req = 1'b1; p0_we = 1'b0; p0_addr = 8'h12;
        #1;
        checks++;
        if (p0_gnt !== 1'b1) begin
            errors++;
            $display("FAIL raw_read_gnt: got %b expected 1", p0_gnt);
        end
        tick;
        p0_req = 1'b0;
        tick;
        checks++;
        if (p0_rvalid !== 1'b1 || p0_rdata !== 32'hABCCCDEF) begin
            errors++;
            $display("FAIL raw_rdata: got %b/%h expected 1/abcccdef", p0_rvalid, p0_rdata);
        end
        checks++;
        if ((p0_rdata < 0) !== 1'b1) begin
            errors++;
            $display("FAIL raw_sign: got %0d expected negative", p0_rdata);
        end
        p0_req = 1'b1; p0_we = 1'b1; p0_addr = 8'hFF; p0_wdata = 32'h7FFF0001;
        #1;
        checks++;
        if (address !== 8'hFF || WE !== 1'b1) begin
            errors++;
            $display("FAIL wrap_write: got %h/%b expected ff/1", address, WE);
        end
        tick;
        p0_req = 1'b0;
        p1_req = 1'b1; p1_we = 1'b0; p1_addr = 8'hFF;
        tick;
        p1_req = 1'b0;
        tick;
        checks++;
        if (p1_rvalid !== 1'b1 || p1_rdata !== 32'h7FFF0001) begin
            errors++;
            $display("FAIL wrap_read: got %b/%h expected 1/7fff0001", p1_rvalid, p1_rdata);
        end
    endtask

    task automatic test_reset_mid_read;
        p0_req = 1'b1; p0_we = 1'b0; p0_addr = 8'h01;
        #1;
        checks++;
        if (p0_gnt !== 1'b1) begin
            errors++;
            $display("FAIL mid_gnt: got %b expected 1", p0_gnt);
        end
        tick;
        p0_addr = 8'h02;
        tick;
        p0_addr = 8'h03;
        tick;
        Reset = 1'b1;
        p0_we = 1'b1; p0_addr = 8'h05; p0_wdata = 32'hDEADBEEF;
        #1;
        checks++;
        if ({p0_gnt, WE} !== 2'b00) begin
            errors++;
            $display("FAIL mid_reset_gnt_we: got %b expected 00", {p0_gnt, WE});
        end
        tick;
        Reset = 1'b0;
        p0_req = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++;
            if (p0_rvalid !== 1'b0 || p0_rdata !== 32'h0) begin
                errors++;
                $display("FAIL mid_discard[%0d]: got %b/%h expected 0/0", k, p0_rvalid, p0_rdata);
            end
            tick;
        end
        p0_req = 1'b1; p0_we = 1'b0; p0_addr = 8'h01;
        p1_req = 1'b1; p1_we = 1'b0; p1_addr = 8'h02;
        #1;
        checks++;
        if ({p0_gnt, p1_gnt} !== 2'b10) begin
            errors++;
            $display("FAIL post_reset_tie: got %b expected 10", {p0_gnt, p1_gnt});
        end
        tick;
        p0_req = 1'b0;
        p1_req = 1'b0;
        tick;
        checks++;
        if (p0_rvalid !== 1'b1 || p0_rdata !== 32'h12345678) begin
            errors++;
            $display("FAIL post_reset_read: got %b/%h expected 1/12345678", p0_rvalid, p0_rdata);
        end
    endtask

    task automatic test_idle;
        tick;
        for (int k = 0; k < 10; k++) begin
            #1;
            checks++;
            if ({WE, p0_gnt, p1_gnt, p0_rvalid, p1_rvalid} !== 5'b0 ||
                address !== 8'h00 || data_in !== 32'h0) begin
                errors++;
                $display("FAIL idle[%0d]: got we/gnt/rv=%b addr=%h din=%h expected 0", k,
                         {WE, p0_gnt, p1_gnt, p0_rvalid, p1_rvalid}, address, data_in);
            end
            tick;
        end
        p1_req = 1'b1; p1_we = 1'b0; p1_addr = 8'h12;
        tick;
        p1_req = 1'b0;
        tick;
        checks++;
        if (p1_rvalid !== 1'b1 || p1_rdata !== 32'hABCCCDEF) begin
            errors++;
            $display("FAIL idle_readback: got %b/%h expected 1/abcccdef", p1_rvalid, p1_rdata);
        end
        p0_req = 1'b1; p0_we = 1'b0; p0_addr = 8'h05;
        tick;
        p0_req = 1'b0;
        tick;
        checks++;
        if (p0_rvalid !== 1'b1 || p0_rdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_write_blocked: got %b/%h expected 1/0", p0_rvalid, p0_rdata);
        end
    endtask

    task automatic test_fixed_priority;
        f0_req = 1'b1;
        f1_req = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            checks++;
            if ({f0_gnt, f1_gnt} !== 2'b10) begin
                errors++;
                $display("FAIL fp_hold[%0d]: got %b expected 10", k, {f0_gnt, f1_gnt});
            end
            tick;
        end
        f0_req = 1'b0;
        #1;
        checks++;
        if ({f0_gnt, f1_gnt} !== 2'b01) begin
            errors++;
            $display("FAIL fp_release: got %b expected 01", {f0_gnt, f1_gnt});
        end
        tick;
        f1_req = 1'b0;
    endtask

    initial begin
        Reset = 1'b1;
        p0_req = 1'b0; p0_we = 1'b0; p0_addr = '0; p0_wdata = '0;
        p1_req = 1'b0; p1_we = 1'b0; p1_addr = '0; p1_wdata = '0;
        f0_req = 1'b0; f1_req = 1'b0; f_data_out = '0;
        test_reset;
        test_single_write;
        test_round_robin;
        test_signed_raw;
        test_reset_mid_read;
        test_idle;
        test_fixed_priority;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/moment_ram_arbiter.md
Name: moment_ram_arbiter

Overview:
- Shares one single-port moment_ram (DEPTH words × DATA_WIDTH, signed) between two requesters:
  - port 0: LBM collision/streaming engine.
  - port 1: display/readout path.
- Per-port req/gnt handshake; per-cycle arbitration, round-robin or fixed priority.
- Tracks in-flight reads and returns read data to the issuing port with a valid pulse.
- Sits between the compute/display logic and the moment_ram instance.

Parameters:
- DEPTH, 256, number of moment words in the RAM (16×16 lattice).
- ADDRESS_WIDTH, $clog2(DEPTH), address width.
- DATA_WIDTH, 32, signed moment word width.
- READ_LATENCY, 1, cycles from ram address/WE=0 presented to ram_data_out valid (1..4).
- FIXED_PRIORITY, 0, 0 = round-robin; 1 = port 0 always wins.

Ports:
- Clk  input  1  system clock (50 MHz).
- Reset  input  1  synchronous, active-high reset.
- p0_req  input  1  port 0 access request.
- p0_we  input  1  port 0 write (1) / read (0).
- p0_addr  input  ADDRESS_WIDTH  port 0 word address.
- p0_wdata  input  DATA_WIDTH  port 0 write data, signed.
- p0_gnt  output  1  port 0 request accepted this cycle.
- p0_rvalid  output  1  port 0 read data valid.
- p0_rdata  output  DATA_WIDTH  port 0 read data, signed.
- p1_req, p1_we, p1_addr, p1_wdata, p1_gnt, p1_rvalid, p1_rdata: same as port 0, for port 1.
- address  output  ADDRESS_WIDTH  to moment_ram address.
- WE  output  1  to moment_ram WE.
- data_in  output  DATA_WIDTH  to moment_ram data_in.
- data_out  input  DATA_WIDTH  from moment_ram data_out.

Behaviour:
- Reset values: all gnt/rvalid = 0; rdata = 0; address = 0; WE = 0; data_in = 0; last_winner = 1, so port 0 wins the first tie; read-tracking pipeline cleared.
- Handshake:
  - A requester holds req, we, addr and wdata stable until it sees gnt.
  - gnt is combinational from req and last_winner in the same cycle.
  - A transaction completes on any cycle with req & gnt.
  - At most one gnt per cycle.
- Arbitration:
  - Only one requester: it wins.
  - Both requesting, FIXED_PRIORITY = 0: the port that is not last_winner wins.
  - Both requesting, FIXED_PRIORITY = 1: port 0 wins.
  - last_winner updates on every grant.
- RAM drive is combinational from the winner in the same cycle:
  - address = winner addr.
  - WE = winner we.
  - data_in = winner wdata.
  - No grant: WE = 0, address = 0, data_in = 0.
- Write: RAM is written at the Clk edge ending the grant cycle. No rvalid is generated.
- Read tracking:
  - A granted read pushes {valid = 1, port id} into a READ_LATENCY-deep shift register.
  - When the entry exits, that port's rvalid pulses for exactly 1 cycle.
  - rdata is registered: it captures data_out on the exit edge and holds until the port's next rvalid.
  - Back-to-back reads, one per cycle, return in issue order with no bubbles.
- Out-of-range address (addr ≥ DEPTH, possible only when DEPTH is not a power of 2):
  - Still granted.
  - Writes are suppressed (WE = 0).
  - Reads return rdata = 0 with normal rvalid timing.
- Read-after-write to the same address on consecutive grants returns the new data.
- Reset asserted mid-operation:
  - All in-flight reads are discarded; no rvalid is emitted for them.
  - gnt is forced to 0 during reset cycles.
  - A write granted in the same cycle as Reset is not performed (WE = 0 while Reset = 1).
- Starvation bound: with FIXED_PRIORITY = 0 and both ports continuously requesting, each port is granted at least every 2nd cycle.

Test Plan:
- Reset then single write:
  - Stimulus: Reset 2 cycles; p0 writes addr 0x01 ← 0x1234_5678.
  - Required: p0_gnt = 1 that cycle with WE = 1, address = 0x01.
  - Follow-up: p0 reads 0x01; p0_rvalid exactly READ_LATENCY+1 cycles after the read grant edge, p0_rdata = 0x1234_5678.
- Contention, round-robin:
  - Stimulus: p0 and p1 both hold read requests for 6 cycles (addr 0x02, 0x03).
  - Required: grants alternate p0, p1, p0, p1, …; rvalids alternate to match; no cycle has both gnt.
- Fixed priority:
  - Stimulus: FIXED_PRIORITY = 1, both ports requesting.
  - Required: p1_gnt stays 0 until p0_req drops; then p1 is granted the next cycle.
- Signed data and read-after-write:
  - Stimulus: p1 writes 0xABCC_CDEF (negative) to 0x12; p0 reads 0x12 on the next cycle.
  - Required: p0_rdata = 0xABCC_CDEF.
  - Also: address 0xFF write/read round-trips (wrap boundary).
- Reset mid-read:
  - Stimulus: issue p0 reads to 0x01–0x03, then assert Reset one cycle after the last grant.
  - Required: no p0_rvalid after Reset; p0_rdata = 0; next post-reset tie goes to p0.
- Idle:
  - Stimulus: no requests for 10 cycles.
  - Required: WE = 0, address = 0, no gnt, no rvalid, RAM contents unchanged (verified by a later readback).
